// File: rtl/sram_pkg.sv
// Shared definitions for the simple-dual-port SRAM: collision modes, clear FSM encoding
// and byte-enable width helper.
package sram_pkg;
  localparam int WRITE_MODE_READ_FIRST    = 0;
  localparam int WRITE_MODE_WRITE_THROUGH = 1;

  typedef logic [0:0] sram_state_t;
  localparam sram_state_t ST_READY = 1'b0;
  localparam sram_state_t ST_CLEAR = 1'b1;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction
endpackage

// File: rtl/sram_clear_ctrl.sv
// Clear engine: walks every address once writing the clear value, owning the array
// write port while busy.
module sram_clear_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int RAM_DEPTH      = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam sram_state_t ST_AFTER_RST = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  sram_state_t           state_d, state_q;
  logic [ADDR_WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_READY) begin
      if (clr) begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    end else begin
      // A fresh request wins over finishing, so the sweep always covers every word
      if (clr) begin
        cnt_d = '0;
      end else if (cnt_q == LAST_ADDR) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_AFTER_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = cnt_q;
endmodule

// File: rtl/sram_sync_2p.sv
// Simple-dual-port synchronous SRAM with byte-enable writes, 1/2-cycle registered reads,
// selectable same-address collision rule and a built-in clear engine.
module sram_sync_2p
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   addr_w,
  input  logic [DATA_WIDTH-1:0]   data_w,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr_r,
  input  logic                    re,
  output logic [DATA_WIDTH-1:0]   data_r,
  output logic                    valid_r,
  input  logic                    clr,
  output logic                    busy
);
  localparam int BEW = be_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic                  busy_i, clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram_clear_ctrl #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .RAM_DEPTH     (RAM_DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .busy    (busy_i),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );
  assign busy = busy_i;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  w_hit, r_ok, rd_acc, wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data, rd_word;
  logic [BEW-1:0]        wr_be;

  always_comb begin
    w_hit   = we && !busy_i && ({1'b0, addr_w} < DEPTH_L);
    r_ok    = ({1'b0, addr_r} < DEPTH_L);
    rd_acc  = re && !busy_i;
    wr_en   = clr_we || w_hit;
    wr_addr = clr_we ? clr_addr : addr_w;
    wr_data = clr_we ? CLEAR_VALUE : data_w;
    wr_be   = clr_we ? '1 : be;
    rd_word = r_ok ? mem[addr_r] : '0;
    // Write-through forwards the merged word; read-first keeps the array's old word
    if (WRITE_MODE == WRITE_MODE_WRITE_THROUGH && w_hit && addr_w == addr_r) begin
      for (int i = 0; i < BEW; i++) begin
        if (be[i]) rd_word[8*i +: 8] = data_w[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BEW; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  logic                  vld1_d, vld1_q;
  logic [DATA_WIDTH-1:0] dat1_d, dat1_q;

  always_comb begin
    vld1_d = rd_acc;
    dat1_d = rd_acc ? rd_word : dat1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1_q <= 1'b0;
      dat1_q <= '0;
    end else begin
      vld1_q <= vld1_d;
      dat1_q <= dat1_d;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  vld2_d, vld2_q;
      logic [DATA_WIDTH-1:0] dat2_d, dat2_q;

      always_comb begin
        vld2_d = vld1_q;
        dat2_d = vld1_q ? dat1_q : dat2_q;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld2_q <= 1'b0;
          dat2_q <= '0;
        end else begin
          vld2_q <= vld2_d;
          dat2_q <= dat2_d;
        end
      end

      assign data_r  = dat2_q;
      assign valid_r = vld2_q;
    end else begin : g_lat1
      assign data_r  = dat1_q;
      assign valid_r = vld1_q;
    end
  endgenerate
endmodule

// File: tb/tb_sram_sync_2p.sv
// Bench for sram_sync_2p: four configurations share one stimulus stream; a word-level
// model with a pending-result queue predicts busy, valid_r and data_r every cycle.
module tb_sram_sync_2p;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  addr_w, addr_r;
  logic [15:0] data_w;
  logic        we, re, clr;
  logic [1:0]  be;

  logic [15:0] data_r [4];
  logic        valid_r [4];
  logic        busy [4];

  sram_sync_2p #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_DEPTH(256), .READ_LATENCY(1),
    .WRITE_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) u0 (
    .clk(clk), .rst(rst), .addr_w(addr_w), .data_w(data_w), .we(we), .be(be),
    .addr_r(addr_r), .re(re), .data_r(data_r[0]), .valid_r(valid_r[0]), .clr(clr), .busy(busy[0]));
  sram_sync_2p #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_DEPTH(256), .READ_LATENCY(2),
    .WRITE_MODE(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) u1 (
    .clk(clk), .rst(rst), .addr_w(addr_w), .data_w(data_w), .we(we), .be(be),
    .addr_r(addr_r), .re(re), .data_r(data_r[1]), .valid_r(valid_r[1]), .clr(clr), .busy(busy[1]));
  sram_sync_2p #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_DEPTH(200), .READ_LATENCY(2),
    .WRITE_MODE(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h1111)) u2 (
    .clk(clk), .rst(rst), .addr_w(addr_w), .data_w(data_w), .we(we), .be(be),
    .addr_r(addr_r), .re(re), .data_r(data_r[2]), .valid_r(valid_r[2]), .clr(clr), .busy(busy[2]));
  sram_sync_2p #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_DEPTH(256), .READ_LATENCY(1),
    .WRITE_MODE(0), .CLEAR_ON_RESET(0), .CLEAR_VALUE(16'h0000)) u3 (
    .clk(clk), .rst(rst), .addr_w(addr_w), .data_w(data_w), .we(we), .be(be),
    .addr_r(addr_r), .re(re), .data_r(data_r[3]), .valid_r(valid_r[3]), .clr(clr), .busy(busy[3]));

  // Model configuration for instances 0..2
  int          rl  [3] = '{1, 2, 2};
  int          wm  [3] = '{0, 1, 0};
  int          dep [3] = '{256, 256, 200};
  logic [15:0] cv  [3] = '{16'hA5A5, 16'hA5A5, 16'h1111};

  typedef struct {
    int          inst;
    logic [15:0] d;
    int          due;
  } rd_t;

  logic [15:0] mm [3][256];
  bit          mbusy [3];
  int          mpos [3];
  rd_t         pend [$];
  logic [15:0] exp_data [3];
  bit          exp_valid [3];
  int          edge_n;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mbusy[k]     = 1'b1;
      mpos[k]      = 0;
      exp_data[k]  = 16'h0;
      exp_valid[k] = 1'b0;
    end
    pend.delete();
    edge_n = 0;
  endtask

  // One rising edge of behaviour, using the inputs that were sampled at that edge
  task automatic model_step();
    logic [15:0] rd;
    edge_n++;
    for (int k = 0; k < 3; k++) begin
      exp_valid[k] = 1'b0;
      if (mbusy[k]) begin
        mm[k][mpos[k]] = cv[k];
        if (clr) mpos[k] = 0;
        else if (mpos[k] == dep[k] - 1) mbusy[k] = 1'b0;
        else mpos[k]++;
      end else begin
        if (re) begin
          rd = (int'(addr_r) < dep[k]) ? mm[k][addr_r] : 16'h0;
          if (wm[k] == 1 && we && addr_w == addr_r && int'(addr_w) < dep[k]) begin
            if (be[0]) rd[7:0]  = data_w[7:0];
            if (be[1]) rd[15:8] = data_w[15:8];
          end
          pend.push_back('{k, rd, edge_n + rl[k] - 1});
        end
        if (we && int'(addr_w) < dep[k]) begin
          if (be[0]) mm[k][addr_w][7:0]  = data_w[7:0];
          if (be[1]) mm[k][addr_w][15:8] = data_w[15:8];
        end
        if (clr) begin
          mbusy[k] = 1'b1;
          mpos[k]  = 0;
        end
      end
    end
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == edge_n) begin
        exp_valid[pend[i].inst] = 1'b1;
        exp_data[pend[i].inst]  = pend[i].d;
        pend.delete(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(negedge clk);
    rst = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_data%0d", k), data_r[k], 16'h0);
      chk($sformatf("rst_valid%0d", k), valid_r[k], 1'b0);
      chk($sformatf("rst_busy%0d", k), busy[k], (k == 3) ? 1'b0 : 1'b1);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("busy%0d@%0d", k, edge_n), busy[k], mbusy[k]);
        chk($sformatf("valid%0d@%0d", k, edge_n), valid_r[k], exp_valid[k]);
        chk($sformatf("data%0d@%0d", k, edge_n), data_r[k], exp_data[k]);
      end
    end
  end

  initial begin
    int n;
    bit vseen;
    rst = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0; be = 2'b00;
    addr_w = 8'h0; addr_r = 8'h0; data_w = 16'h0;
    do_reset();

    n = 0;
    while (busy[0] && n < 400) begin tick(); n++; end
    chk("clear_len", n, 256);

    re = 1'b1; addr_r = 8'd0;   tick(); chk("rd0", data_r[0], 16'hA5A5);
    chk("rd0_valid", valid_r[0], 1'b1);
    addr_r = 8'd128; tick(); chk("rd128", data_r[0], 16'hA5A5);
    addr_r = 8'd255; tick(); chk("rd255", data_r[0], 16'hA5A5);
    re = 1'b0; tick();

    we = 1'b1; addr_w = 8'd5; data_w = 16'h1234; be = 2'b11; tick();
    data_w = 16'hFF00; be = 2'b10; tick();
    we = 1'b0; re = 1'b1; addr_r = 8'd5; tick();
    chk("be_merge", data_r[0], 16'hFF34);
    chk("be_merge_valid", valid_r[0], 1'b1);
    re = 1'b0; tick();
    chk("valid_pulse", valid_r[0], 1'b0);

    re = 1'b1; addr_r = 8'd3;
    for (int t = 0; t < 6; t++) begin
      if (t == 4) re = 1'b0;
      tick();
      chk($sformatf("lat2_t%0d", t), valid_r[1], (t >= 1 && t <= 4));
    end

    we = 1'b1; addr_w = 8'd7; data_w = 16'h0001; be = 2'b11; tick();
    data_w = 16'h0002; be = 2'b01; re = 1'b1; addr_r = 8'd7; tick();
    chk("coll_wm0_rl1", data_r[0], 16'h0001);
    we = 1'b0; re = 1'b0; tick();
    chk("coll_wm1_rl2", data_r[1], 16'h0002);
    chk("coll_wm0_rl2", data_r[2], 16'h0001);

    clr = 1'b1; tick(); clr = 1'b0;
    n = 0; vseen = 1'b0;
    while (busy[0] && n < 1000) begin
      clr = (n == 99);
      we = 1'b1; addr_w = 8'd9; data_w = 16'h1234; be = 2'b11;
      re = 1'b1; addr_r = 8'd9;
      tick(); n++;
      if (valid_r[0]) vseen = 1'b1;
    end
    chk("restart_len", n, 356);
    chk("no_valid_busy", vseen, 1'b0);
    clr = 1'b0; we = 1'b0; re = 1'b1; addr_r = 8'd9; tick();
    chk("addr9_cleared", data_r[0], 16'hA5A5);
    re = 1'b0; tick();

    we = 1'b1; addr_w = 8'd210; data_w = 16'hBEEF; be = 2'b11; re = 1'b1; addr_r = 8'd210; tick();
    we = 1'b0; addr_r = 8'd10; tick();
    chk("oor_data", data_r[2], 16'h0);
    chk("oor_valid", valid_r[2], 1'b1);
    re = 1'b0; tick();
    chk("oor_alias_unchanged", data_r[2], 16'h1111);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1600) do_reset();
      we     = ($urandom_range(0, 1) == 1);
      re     = ($urandom_range(0, 1) == 1);
      be     = 2'($urandom_range(0, 3));
      addr_w = 8'($urandom_range(0, 255));
      addr_r = ($urandom_range(0, 3) == 0) ? addr_w : 8'($urandom_range(0, 255));
      data_w = 16'($urandom);
      clr    = (i == 1500) || ($urandom_range(0, 399) == 0);
      tick();
    end
    we = 1'b0; re = 1'b0; clr = 1'b0;
    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
